tank_level_monitor: RTL and testbench

- Multi-tank successor to the single-tank high-level sensor logic in the irrigation controller.
- Each channel measures valve-open fill time in seconds against a per-tank preset. When the fill time expires, the channel drives that tank's high-level sensor line.
- Each channel also flags overfill (valve still open after full).
- Sits between the preset/valve control FSM and the pump/valve interlock. The 1 s tick comes from the shared timebase.

---
 rtl/tank_level_pkg.sv | 30 +++
 rtl/tank_level_monitor_if.sv | 24 ++
 rtl/tank_level_channel.sv | 112 +++++++++++
 rtl/tank_level_monitor.sv | 49 ++++
 tb/tb_tank_level_monitor.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tank_level_pkg.sv
// Shared types and helpers for the multi-tank high-level sensor monitor.
// Holds the channel state encoding, the preset-code width and the preset-to-seconds map.
package tank_level_pkg;

  localparam int PRESET_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILLING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_FULL    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  function automatic int unsigned preset_seconds(
    input logic [PRESET_W-1:0] code,
    input int unsigned         t0,
    input int unsigned         t1,
    input int unsigned         t2,
    input int unsigned         t3
  );
    case (code)
      2'd0:    return t0;
      2'd1:    return t1;
      2'd2:    return t2;
      default: return t3;
    endcase
  endfunction

endpackage

// File: rtl/tank_level_monitor_if.sv
// Bundle of per-tank control and sensor lines between the valve FSM and the interlock.
// master drives the valve/preset/tick side, slave is the monitor itself.
interface tank_level_monitor_if #(
  parameter int N_TANKS = 2
);
  logic                   tick_1s;
  logic [N_TANKS-1:0]     fill_valve;
  logic [N_TANKS-1:0]     drain;
  logic [2*N_TANKS-1:0]   preset_sel;
  logic [N_TANKS-1:0]     high_level_indicator;
  logic [N_TANKS-1:0]     high_level_sensor;
  logic [N_TANKS-1:0]     filling;
  logic [N_TANKS-1:0]     fault;

  modport master (
    output tick_1s, fill_valve, drain, preset_sel, high_level_indicator,
    input  high_level_sensor, filling, fault
  );

  modport slave (
    input  tick_1s, fill_valve, drain, preset_sel, high_level_indicator,
    output high_level_sensor, filling, fault
  );
endinterface

// File: rtl/tank_level_channel.sv
// Single-tank fill timer: FSM, seconds counter and latched fill target.
// Overfill detection is compiled in only when TANK_LEVEL_OVERFILL_EN is defined.
module tank_level_channel
  import tank_level_pkg::*;
#(
  parameter int TIME_W     = 12,
  parameter int FILL_T0    = 900,
  parameter int FILL_T1    = 1320,
  parameter int FILL_T2    = 1800,
  parameter int FILL_T3    = 2700,
  parameter int OVERFILL_S = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_1s,
  input  logic                fill_valve,
  input  logic                drain,
  input  logic [PRESET_W-1:0] preset_sel,
  input  logic                high_level_indicator,
  output logic                high_level_sensor,
  output logic                filling,
  output logic                fault
);

  state_t              state_reg, state_next;
  logic [TIME_W-1:0]   count_reg, count_next;
  logic [TIME_W-1:0]   target_reg, target_next;
  logic [TIME_W-1:0]   count_inc;
  logic [TIME_W-1:0]   preset_target;

  // Saturating increment: the counter never wraps back to zero.
  assign count_inc     = (count_reg == {TIME_W{1'b1}}) ? count_reg : count_reg + 1'b1;
  assign preset_target = TIME_W'(preset_seconds(preset_sel, FILL_T0, FILL_T1, FILL_T2, FILL_T3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      target_reg <= TIME_W'(FILL_T0);
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    target_next = target_reg;
    if (drain) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fill_valve) begin
            target_next = preset_target;
            count_next  = '0;
            state_next  = ST_FILLING;
          end
        end
        ST_FILLING: begin
          // Expiry takes precedence over the valve closing in the same cycle.
          if (tick_1s && (count_reg == target_reg - 1'b1)) begin
            state_next = ST_FULL;
            count_next = '0;
          end else begin
            if (tick_1s) count_next = count_inc;
            if (!fill_valve) state_next = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (fill_valve) state_next = ST_FILLING;
        end
        ST_FULL: begin
`ifdef TANK_LEVEL_OVERFILL_EN
          if (!fill_valve) begin
            count_next = '0;
          end else if (tick_1s) begin
            count_next = count_inc;
            if (count_inc >= TIME_W'(OVERFILL_S)) state_next = ST_FAULT;
          end
`endif
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

`ifndef TANK_LEVEL_OVERFILL_EN
  logic [TIME_W-1:0] unused_overfill;
  assign unused_overfill = TIME_W'(OVERFILL_S);
`endif

  always_comb begin
    high_level_sensor = ((state_reg == ST_FULL) || (state_reg == ST_FAULT)) && high_level_indicator;
    filling           = (state_reg == ST_FILLING);
`ifdef TANK_LEVEL_OVERFILL_EN
    fault             = (state_reg == ST_FAULT);
`else
    fault             = 1'b0;
`endif
  end

endmodule

// File: rtl/tank_level_monitor.sv
// Multi-tank high-level sensor monitor: N_TANKS independent fill-timer channels.
// Optional overfill fault detection is enabled by defining TANK_LEVEL_OVERFILL_EN.
module tank_level_monitor
  import tank_level_pkg::*;
#(
  parameter int N_TANKS    = 2,
  parameter int TIME_W     = 12,
  parameter int FILL_T0    = 900,
  parameter int FILL_T1    = 1320,
  parameter int FILL_T2    = 1800,
  parameter int FILL_T3    = 2700,
  parameter int OVERFILL_S = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tank_level_monitor_if.slave  bus
);

  logic [N_TANKS-1:0] sensor_vec;
  logic [N_TANKS-1:0] filling_vec;
  logic [N_TANKS-1:0] fault_vec;

  for (genvar gi = 0; gi < N_TANKS; gi++) begin : g_ch
    tank_level_channel #(
      .TIME_W     (TIME_W),
      .FILL_T0    (FILL_T0),
      .FILL_T1    (FILL_T1),
      .FILL_T2    (FILL_T2),
      .FILL_T3    (FILL_T3),
      .OVERFILL_S (OVERFILL_S)
    ) u_ch (
      .clk                  (clk),
      .rst_n                (rst_n),
      .tick_1s              (bus.tick_1s),
      .fill_valve           (bus.fill_valve[gi]),
      .drain                (bus.drain[gi]),
      .preset_sel           (bus.preset_sel[PRESET_W*gi +: PRESET_W]),
      .high_level_indicator (bus.high_level_indicator[gi]),
      .high_level_sensor    (sensor_vec[gi]),
      .filling              (filling_vec[gi]),
      .fault                (fault_vec[gi])
    );
  end

  assign bus.high_level_sensor = sensor_vec;
  assign bus.filling           = filling_vec;
  assign bus.fault             = fault_vec;

endmodule

// File: tb/tb_tank_level_monitor.sv
// Testbench for tank_level_monitor: directed scenarios followed by random traffic,
// all checked against a per-tank behavioural model of the fill/overfill rules.
module tb_tank_level_monitor;

  localparam int NT  = 2;
  localparam int FT0 = 4;
  localparam int FT1 = 5;
  localparam int FT2 = 6;
  localparam int FT3 = 7;
  localparam int OVF = 3;
`ifdef TANK_LEVEL_OVERFILL_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  tank_level_monitor_if #(.N_TANKS(NT)) bus ();

  tank_level_monitor #(
    .N_TANKS(NT), .TIME_W(12), .FILL_T0(FT0), .FILL_T1(FT1),
    .FILL_T2(FT2), .FILL_T3(FT3), .OVERFILL_S(OVF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a fill is "started" until the tank is full; "running" while the valve counts time.
  int fill_tab[4] = '{FT0, FT1, FT2, FT3};
  bit m_started[NT], m_running[NT], m_full[NT], m_fault[NT];
  int m_secs[NT], m_wet[NT], m_goal[NT];

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      m_started[i] = 0; m_running[i] = 0; m_full[i] = 0; m_fault[i] = 0;
      m_secs[i] = 0; m_wet[i] = 0; m_goal[i] = FT0;
    end
  endfunction

  function automatic void model_update();
    for (int i = 0; i < NT; i++) begin
      bit v, t;
      v = bus.fill_valve[i];
      t = bus.tick_1s;
      if (bus.drain[i]) begin
        m_started[i] = 0; m_running[i] = 0; m_full[i] = 0; m_fault[i] = 0;
        m_secs[i] = 0; m_wet[i] = 0;
      end else if (m_fault[i]) begin
        // held until drained
      end else if (m_full[i]) begin
        if (OVF_ON) begin
          if (!v) m_wet[i] = 0;
          else if (t) begin
            m_wet[i] = m_wet[i] + 1;
            if (m_wet[i] >= OVF) m_fault[i] = 1;
          end
        end
      end else if (m_started[i]) begin
        if (m_running[i]) begin
          if (t) m_secs[i] = m_secs[i] + 1;
          if (t && m_secs[i] == m_goal[i]) begin
            m_full[i] = 1; m_started[i] = 0; m_running[i] = 0;
            m_secs[i] = 0; m_wet[i] = 0;
          end else if (!v) m_running[i] = 0;
        end else if (v) m_running[i] = 1;
      end else if (v) begin
        m_goal[i] = fill_tab[bus.preset_sel[2*i +: 2]];
        m_secs[i] = 0; m_started[i] = 1; m_running[i] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NT-1:0] eh, ef, ex;
    for (int i = 0; i < NT; i++) begin
      eh[i] = m_full[i] & bus.high_level_indicator[i];
      ef[i] = m_started[i] & m_running[i];
      ex[i] = m_fault[i];
    end
    chk({tag, "_sensor"}, 32'(bus.high_level_sensor), 32'(eh));
    chk({tag, "_filling"}, 32'(bus.filling), 32'(ef));
    chk({tag, "_fault"}, 32'(bus.fault), 32'(ex));
    $display("cycle t=%0t %s sensor=%b filling=%b fault=%b", $time, tag,
             bus.high_level_sensor, bus.filling, bus.fault);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
    bus.tick_1s = 1'b0;
    bus.drain   = '0;
  endtask

  task automatic tick_step(input string tag);
    step({tag, "_gap"});
    bus.tick_1s = 1'b1;
    step(tag);
  endtask

  initial begin
    bus.tick_1s = 0; bus.fill_valve = '0; bus.drain = '0;
    bus.preset_sel = '0; bus.high_level_indicator = '1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_model("reset");
    #10 rst_n = 1'b1;

    // Base fill with preset 1 (5 s)
    bus.preset_sel[1:0] = 2'd1;
    bus.fill_valve[0] = 1'b1;
    step("base_start");
    chk("base_filling0", 32'(bus.filling[0]), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick_step("base_tick");
      if (k == 4) chk("base_not_full_yet", 32'(bus.high_level_sensor[0]), 32'd0);
    end
    chk("base_sensor0", 32'(bus.high_level_sensor[0]), 32'd1);
    chk("base_tank1_idle", 32'({bus.high_level_sensor[1], bus.filling[1], bus.fault[1]}), 32'd0);

    // Indicator gating while FULL
    bus.high_level_indicator[0] = 1'b0;
    #1 chk("gate_off", 32'(bus.high_level_sensor[0]), 32'd0);
    step("gate_hold");
    bus.high_level_indicator[0] = 1'b1;
    #1 chk("gate_on", 32'(bus.high_level_sensor[0]), 32'd1);

    // Overfill: valve kept open in FULL
    for (int k = 0; k < 3; k++) tick_step("ovf_tick");
    chk("ovf_fault0", 32'(bus.fault[0]), 32'(OVF_ON));
    bus.drain[0] = 1'b1;
    bus.fill_valve[0] = 1'b0;
    step("ovf_drain");
    chk("drain_clears", 32'({bus.high_level_sensor[0], bus.filling[0], bus.fault[0]}), 32'd0);

    // Pause, then preset change is ignored on resume
    bus.preset_sel[1:0] = 2'd0;
    bus.fill_valve[0] = 1'b1;
    step("pause_start");
    tick_step("pause_t1");
    tick_step("pause_t2");
    bus.fill_valve[0] = 1'b0;
    step("pause_close");
    for (int k = 0; k < 3; k++) tick_step("pause_idle_tick");
    bus.preset_sel[1:0] = 2'd3;
    bus.fill_valve[0] = 1'b1;
    step("pause_reopen");
    tick_step("pause_t3");
    chk("pause_not_full", 32'(bus.high_level_sensor[0]), 32'd0);
    tick_step("pause_t4");
    chk("pause_full_at4", 32'(bus.high_level_sensor[0]), 32'd1);
    bus.fill_valve[0] = 1'b0;
    step("pause_valve_off");
    bus.drain[0] = 1'b1;
    step("pause_drain");

    // drain together with tick at count 3
    bus.preset_sel[1:0] = 2'd2;
    bus.fill_valve[0] = 1'b1;
    step("dt_start");
    for (int k = 0; k < 3; k++) tick_step("dt_tick");
    bus.tick_1s = 1'b1; bus.drain[0] = 1'b1; bus.fill_valve[0] = 1'b0;
    step("dt_both");
    chk("dt_idle", 32'({bus.high_level_sensor[0], bus.filling[0]}), 32'd0);
    step("dt_after");

    // Expiring tick together with valve falling
    bus.preset_sel[1:0] = 2'd0;
    bus.fill_valve[0] = 1'b1;
    step("ef_start");
    for (int k = 0; k < 3; k++) tick_step("ef_tick");
    bus.tick_1s = 1'b1; bus.fill_valve[0] = 1'b0;
    step("ef_both");
    chk("ef_full", 32'({bus.high_level_sensor[0], bus.filling[0]}), 32'b10);
    bus.drain[0] = 1'b1;
    step("ef_drain");

    // Asynchronous reset in mid-fill
    bus.fill_valve[0] = 1'b1;
    step("ar_start");
    tick_step("ar_t1");
    tick_step("ar_t2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_outputs_zero", 32'({bus.high_level_sensor, bus.filling, bus.fault}), 32'd0);
    #2 rst_n = 1'b1;
    step("ar_restart");
    chk("ar_filling", 32'(bus.filling[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick_step("ar_tick");
      if (k == 3) chk("ar_from_zero", 32'(bus.high_level_sensor[0]), 32'd0);
    end
    chk("ar_full", 32'(bus.high_level_sensor[0]), 32'd1);
    bus.drain = '1;
    bus.fill_valve = '0;
    step("ar_drain");

    // Random traffic on both tanks
    for (int c = 0; c < 800; c++) begin
      bus.tick_1s = ($urandom_range(2) == 0);
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(7) == 0) bus.fill_valve[i] = ~bus.fill_valve[i];
        bus.drain[i] = ($urandom_range(49) == 0);
        if ($urandom_range(19) == 0) bus.preset_sel[2*i +: 2] = 2'($urandom_range(3));
        bus.high_level_indicator[i] = ($urandom_range(5) != 0);
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
